// File: rtl/imager_pixel_packer.sv
// Packs SPW narrow sensor samples into one pipe word and buffers the words in a FIFO for okPipeOut.
// Optional build macro IMAGER_PACKER_TESTPAT_EN replaces s_data with an internal ramp counter.
module imager_pixel_packer #(
  parameter int IN_W             = 6,
  parameter int SPW              = 4,
  parameter int OUT_W            = 32,
  parameter int DEPTH            = 65536,
  parameter int PROG_FULL_THRESH = 43200
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [IN_W-1:0]          s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  input  logic                     rd_en,
  output logic [OUT_W-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic                     prog_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              frame_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = (SPW > 1) ? $clog2(SPW) : 1;

  logic [OUT_W-1:0] mem [DEPTH];

  logic [OUT_W-1:0] pack_q;
  logic [IDX_W-1:0] idx_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             empty_q, full_q, prog_full_q, overflow_q;
  logic [OUT_W-1:0] rd_data_q;
  logic [15:0]      frame_cnt_q;

  logic [IN_W-1:0]  sample;
  logic [OUT_W-1:0] word_d;
  logic             last_slot, push_req, do_push, do_pop;

`ifdef IMAGER_PACKER_TESTPAT_EN
  logic [IN_W-1:0] tp_q;
  logic            unused_sdata;

  assign unused_sdata = ^s_data;
  assign sample       = tp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q <= '0;
    end else if (clr) begin
      tp_q <= '0;
    end else if (s_valid) begin
      tp_q <= tp_q + IN_W'(1);
    end
  end
`else
  assign sample = s_data;
`endif

  // Slot k lands at the k-th field counted down from the top of the packed region.
  always_comb begin
    word_d = pack_q;
    for (int k = 0; k < SPW; k++) begin
      if (idx_q == IDX_W'(k)) begin
        word_d[(SPW-k)*IN_W-1 -: IN_W] = sample;
      end
    end
  end

  assign last_slot = (idx_q == IDX_W'(SPW-1));
  assign push_req  = s_valid && !clr && (last_slot || s_last);
  assign do_push   = push_req && !full_q;
  assign do_pop    = rd_en && !clr && !empty_q;

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= word_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q      <= '0;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      prog_full_q <= 1'b0;
      overflow_q  <= 1'b0;
      rd_data_q   <= '0;
      frame_cnt_q <= '0;
    end else if (clr) begin
      pack_q      <= '0;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      prog_full_q <= 1'b0;
      overflow_q  <= 1'b0;
      rd_data_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (s_valid) begin
        if (push_req) begin
          pack_q <= '0;
          idx_q  <= '0;
        end else begin
          pack_q <= word_d;
          idx_q  <= idx_q + IDX_W'(1);
        end
      end
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
        rd_data_q <= mem[rd_ptr_q];
      end
      // Flags are judged on the pre-pop state, so a read in the same cycle does not rescue a push into a full FIFO.
      if (push_req && full_q) begin
        overflow_q <= 1'b1;
      end
      if (do_push && s_last) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      level_q     <= level_d;
      empty_q     <= (level_d == '0);
      full_q      <= (level_d == LVL_W'(DEPTH));
      prog_full_q <= (level_d >= LVL_W'(PROG_FULL_THRESH));
    end
  end

  assign rd_data   = rd_data_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign prog_full = prog_full_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_imager_pixel_packer.sv
// Directed bench for imager_pixel_packer on a 16-entry FIFO with a prog_full level of 12.
module tb_imager_pixel_packer;

  localparam int DEPTH  = 16;
  localparam int THRESH = 12;

  logic        clk, rst_n, clr;
  logic [5:0]  s_data;
  logic        s_valid, s_last, rd_en;
  logic [31:0] rd_data;
  logic        empty, full, prog_full, overflow;
  logic [4:0]  level;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;

  imager_pixel_packer #(
    .IN_W(6), .SPW(4), .OUT_W(32), .DEPTH(DEPTH), .PROG_FULL_THRESH(THRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .prog_full(prog_full),
    .level(level), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic read_word();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; clr = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; rd_en = 1'b0;
    #3 rst_n = 1'b0;
    #2;
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_empty", {31'b0, empty}, 32'h1);
    chk("rst_full", {31'b0, full}, 32'h0);
    chk("rst_prog_full", {31'b0, prog_full}, 32'h0);
    chk("rst_level", {27'b0, level}, 32'h0);
    chk("rst_overflow", {31'b0, overflow}, 32'h0);
    chk("rst_frame_cnt", {16'b0, frame_cnt}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

`ifdef IMAGER_PACKER_TESTPAT_EN
    for (int i = 0; i < 4; i++) send(6'h2A, 1'b0);
    chk("tp_level", {27'b0, level}, 32'd1);
    for (int i = 0; i < 4; i++) send(6'h15, 1'b0);
    read_word();
    chk("tp_word0", rd_data, 32'h0000_1083);
    read_word();
    chk("tp_word1", rd_data, 32'h0010_5187);
    chk("tp_empty", {31'b0, empty}, 32'h1);
`else
    // Two full words back to back
    for (int i = 1; i <= 8; i++) send(6'(i), 1'b0);
    chk("t1_level", {27'b0, level}, 32'd2);
    read_word();
    chk("t1_word0", rd_data, 32'h0004_20C4);
    read_word();
    chk("t1_word1", rd_data, 32'h0014_61C8);
    chk("t1_frame_cnt", {16'b0, frame_cnt}, 32'd0);
    chk("t1_empty", {31'b0, empty}, 32'h1);

    // Partial word flushed by s_last
    send(6'h3F, 1'b0);
    send(6'h01, 1'b1);
    chk("t2_level", {27'b0, level}, 32'd1);
    chk("t2_frame_cnt", {16'b0, frame_cnt}, 32'd1);
    read_word();
    chk("t2_word", rd_data, 32'h00FC_1000);

    // Fill to full, then one more push is dropped
    for (int i = 1; i <= 16; i++) begin
      send(6'(i), 1'b1);
      chk("t3_fill_level", {27'b0, level}, 32'(i));
      chk("t3_fill_pfull", {31'b0, prog_full}, (i >= THRESH) ? 32'h1 : 32'h0);
    end
    chk("t3_full", {31'b0, full}, 32'h1);
    chk("t3_ovf_before", {31'b0, overflow}, 32'h0);
    s_valid = 1'b1; s_data = 6'd17; s_last = 1'b1; rd_en = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0; rd_en = 1'b0;
    chk("t3_overflow", {31'b0, overflow}, 32'h1);
    chk("t3_level_drop", {27'b0, level}, 32'd15);
    chk("t3_frame_cnt", {16'b0, frame_cnt}, 32'd17);
    chk("t3_first_word", rd_data, 32'(1) << 18);
    for (int i = 2; i <= 16; i++) begin
      read_word();
      chk("t3_drain_word", rd_data, 32'(i) << 18);
      chk("t3_drain_level", {27'b0, level}, 32'(16 - i));
      chk("t3_drain_pfull", {31'b0, prog_full}, ((16 - i) >= THRESH) ? 32'h1 : 32'h0);
    end
    chk("t3_empty", {31'b0, empty}, 32'h1);
    read_word();
    chk("t3_rd_empty_hold", rd_data, 32'(16) << 18);
    chk("t3_rd_empty_level", {27'b0, level}, 32'd0);

    // Push and pop in the same cycle leave level unchanged
    send(6'd20, 1'b1);
    s_valid = 1'b1; s_data = 6'd21; s_last = 1'b1; rd_en = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0; rd_en = 1'b0;
    chk("sp_level", {27'b0, level}, 32'd1);
    chk("sp_word_a", rd_data, 32'(20) << 18);
    read_word();
    chk("sp_word_b", rd_data, 32'(21) << 18);

    // clr mid-word discards partial state and ignores its own sample
    send(6'd9, 1'b0);
    send(6'd10, 1'b0);
    clr = 1'b1; s_valid = 1'b1; s_data = 6'd11; s_last = 1'b1;
    tick();
    clr = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    chk("t5_clr_ovf", {31'b0, overflow}, 32'h0);
    chk("t5_clr_frame", {16'b0, frame_cnt}, 32'd0);
    chk("t5_clr_rd_data", rd_data, 32'h0);
    for (int i = 1; i <= 4; i++) send(6'(i), 1'b0);
    chk("t5_level", {27'b0, level}, 32'd1);
    read_word();
    chk("t5_word", rd_data, 32'h0004_20C4);
    chk("t5_empty", {31'b0, empty}, 32'h1);
`endif

    // Async reset while a read is in flight
    send(6'd5, 1'b1);
    send(6'd6, 1'b1);
    rd_en = 1'b1;
    tick();
    chk("t6_pre_rd", (rd_data != 32'h0) ? 32'h1 : 32'h0, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rd_data", rd_data, 32'h0);
    chk("t6_empty", {31'b0, empty}, 32'h1);
    chk("t6_level", {27'b0, level}, 32'h0);
    chk("t6_frame_cnt", {16'b0, frame_cnt}, 32'h0);
    rd_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
